// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer with a registered output slot.
package arb_mux_pkg;

  // Arbitration modes
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Select width for an n-channel mux, never below one bit
  function automatic int clog2_min1(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_mux_pipe_rr_pick.sv
// Combinational grant picker: rotate requests so the search base sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
// In fixed-priority mode the base is forced to 0, so the lowest index wins.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int MODE = MODE_RR,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [SELW-1:0]  base_s;
  logic [2*NCH-1:0] dbl_s;
  logic [NCH-1:0]   rot_s;
  logic [SELW-1:0]  rot_idx_s;
  logic [SELW:0]    sum_s;
  logic [SELW:0]    wrap_s;

  // Search base: the rotating pointer in round-robin, bit 0 otherwise
  always_comb begin
    if (MODE == MODE_RR) begin
      base_s = ptr;
    end else begin
      base_s = {SELW{1'b0}};
    end
  end

  // Rotate right by the base and pick the lowest requesting position
  always_comb begin
    dbl_s     = {req, req} >> base_s;
    rot_s     = dbl_s[NCH-1:0];
    rot_idx_s = {SELW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      rot_idx_s = rot_s[i] ? SELW'(i) : rot_idx_s;
    end
  end

  // Rotate the picked index back, wrapping modulo NCH (NCH need not be 2^k)
  always_comb begin
    sum_s   = {1'b0, rot_idx_s} + {1'b0, base_s};
    wrap_s  = (sum_s >= NCH_W) ? (sum_s - NCH_W) : sum_s;
    gnt_idx = wrap_s[SELW-1:0];
    gnt_any = |req;
    for (int i = 0; i < NCH; i++) begin
      gnt[i] = gnt_any & (gnt_idx == SELW'(i));
    end
  end

endmodule

// File: rtl/arb_mux_pipe.sv
// N-channel valid/ready multiplexer with built-in arbitration and one registered
// output slot. The slot reloads whenever it is empty or being drained, so a
// continuously ready consumer sees one transfer per cycle.
module arb_mux_pipe
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  parameter  int MODE  = 1,
  localparam int SELW  = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr_r;
  logic [SELW-1:0]  ptr_nxt_s;
  logic [NCH-1:0]   gnt_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             gnt_any_s;
  logic             load_s;
  logic             xfer_s;
  logic [WIDTH-1:0] sel_data_s;

  rr_pick #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  // Slot can take new data when empty or drained this cycle; nothing is accepted in reset
  always_comb begin
    load_s   = !out_valid || out_ready;
    xfer_s   = gnt_any_s && load_s && rst_n;
    in_ready = gnt_s & {NCH{load_s && rst_n}};
  end

  // One-hot AND-OR selection of the granted channel's data
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sel_data_s = gnt_s[i] ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Pointer moves past the winner only on a transfer, and only in round-robin
  always_comb begin
    if ((MODE == MODE_RR) && xfer_s) begin
      ptr_nxt_s = (gnt_idx_s == LAST_IDX) ? {SELW{1'b0}} : (gnt_idx_s + SELW'(1));
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {SELW{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output slot: refill on transfer, empty on drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_sel   <= {SELW{1'b0}};
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_s;
      out_sel   <= gnt_idx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end
  end

endmodule
